nco_clk_meter: RTL and testbench
================================

// Module: nco_clk_meter
// PURPOSE
//  Measures the 1-bit outputs of the 8-channel NCO bank (code clocks sig_1023k, carriers sig_carrier) so their rates and phases can be verified.
//  For one channel and source at a time, it counts rising edges over a programmed gate window of clk cycles.
//  It also records the gate-relative cycle of the first rising edge, so fre/pha control words can be checked in-system.
// PARAMETERS
//  NUM_CH       8    number of NCO channels monitored
//  GATE_W       28   width of gate_len and first_edge
//  CNT_W        28   width of edge_cnt (saturating)
//  SYNC_STAGES  2    synchronizer flops per input bit (>=2)
// PORTS
//  clk          in   1            system clock (all logic)
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            1-cycle measurement request; honoured only in IDLE
//  ch_sel       in   3            channel to measure (0..NUM_CH-1), latched at start
//  src_sel      in   1            0 = sig_1023k[ch_sel], 1 = sig_carrier[ch_sel], latched at start
//  gate_len     in   GATE_W       gate window length in clk cycles, latched at start
//  sig_1023k    in   NUM_CH       NCO code-clock outputs, treated as asynchronous
//  sig_carrier  in   NUM_CH       NCO carrier outputs, treated as asynchronous
//  busy         out  1            high in ARM, GATE and DONE
//  done         out  1            1-cycle pulse in DONE; results valid from this cycle
//  edge_cnt     out  CNT_W        rising edges seen during the gate
//  first_edge   out  GATE_W       gate cycle index (0-based) of first rising edge
//  no_edge      out  1            1 = no rising edge in gate (first_edge = all ones)
//  overflow     out  1            1 = edge_cnt saturated at all ones
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, edge_cnt, first_edge, no_edge and overflow all 0.
//    Synchronizer flops, edge-detect register and latched config are cleared.
//  - All 2*NUM_CH input bits pass through SYNC_STAGES flops; selection happens after synchronization.
//  - FSM: IDLE -> ARM -> GATE -> DONE -> IDLE.
//    * IDLE: start=1 latches ch_sel, src_sel, gate_len; next state ARM. start=0 stays IDLE.
//    * ARM (1 cycle): prev <= selected synced signal, so no false edge occurs on channel switch.
//      Clears working counters and gate counter. If gate_len==0 next state is DONE, else GATE.
//    * GATE: exactly gate_len cycles, index k=0..gate_len-1.
//      A rising edge is sel=1 & prev=0 in cycle k; prev <= sel every cycle.
//      On the first edge, the working first_edge register <= k.
//      Working count += 1 per edge, saturating at 2^CNT_W-1. An edge arriving at saturation sets overflow.
//    * DONE (1 cycle): output registers <= working values; done=1.
//      No edge seen: first_edge=all ones and no_edge=1. Next state IDLE.
//  - Timing: start sampled at cycle T gives ARM at T+1, GATE at T+2..T+1+gate_len, DONE at T+2+gate_len.
//  - start outside IDLE (including in DONE) is ignored, not queued. ch_sel/src_sel/gate_len changes mid-measurement have no effect.
//  - Outputs hold their last result until the next DONE; done is never high two cycles in a row.
//  - ch_sel >= NUM_CH selects constant 0, giving no_edge=1.
//  - Reset asserted mid-measurement aborts immediately to reset values; no done pulse is issued.
//  - Input-to-count latency is SYNC_STAGES cycles. Edges in the last SYNC_STAGES cycles before ARM fall into the gate.
// TESTING
//  1. ch 0, code, gate_len=1000, input rises every 10 clk -> done at T+1002, edge_cnt=100, no_edge=0, overflow=0.
//  2. gate_len=0 -> done at T+2, edge_cnt=0, no_edge=1, first_edge=all ones.
//  3. Input held high through ARM/GATE, gate_len=50 -> edge_cnt=0, no_edge=1 (no false edge on switch).
//  4. CNT_W=4, 20 edges in gate -> edge_cnt=15, overflow=1. Single rise at gate cycle 37 -> first_edge=37.
//  5. start pulsed at T+5 during busy -> exactly one done; channels 1..7 toggling at different rates do not affect ch 0 result.
//  6. rst pulse during GATE -> all outputs 0, no done. New start afterwards gives a correct result.

Source files
------------

// File: rtl/nco_clk_meter.sv
// nco_clk_meter: rate/phase meter for the NCO bank outputs.
// For one selected channel and source it counts rising edges over a gate window
// of gate_len clk cycles and records the gate cycle of the first rising edge.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             1-cycle request, accepted only when idle
//   ch_sel, src_sel   channel / source (0 = code clock, 1 = carrier), latched at start
//   gate_len          gate window length in cycles, latched at start
//   sig_1023k         NCO code-clock outputs (asynchronous)
//   sig_carrier       NCO carrier outputs (asynchronous)
//   busy              high while a measurement is in progress (ARM, GATE, DONE)
//   done              1-cycle pulse when results are updated
//   edge_cnt          saturating count of rising edges in the gate
//   first_edge        0-based gate cycle of the first rising edge (all ones if none)
//   no_edge           flags an empty measurement (zero edges counted)
//   overflow          edge_cnt saturated
module nco_clk_meter #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned GATE_W      = 28,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        ch_sel,
  input  logic              src_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [NUM_CH-1:0] sig_1023k,
  input  logic [NUM_CH-1:0] sig_carrier,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  edge_cnt,
  output logic [GATE_W-1:0] first_edge,
  output logic              no_edge,
  output logic              overflow
);

  localparam int unsigned IN_W = 2 * NUM_CH;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [SYNC_STAGES-1:0][IN_W-1:0]     sync_q;
  logic [IN_W-1:0]                      synced;
  logic [NUM_CH-1:0]                    src_vec_c, ch_mask_c;
  logic                                 sel_c, rise_c;

  logic [2:0]        ch_q, ch_d;
  logic              src_q, src_d;
  logic [GATE_W-1:0] len_q, len_d;
  logic              prev_q, prev_d;
  logic [GATE_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [GATE_W-1:0] wfirst_q, wfirst_d;
  logic              wseen_q, wseen_d;
  logic              wovf_q, wovf_d;

  logic              busy_d, done_d, no_edge_d, overflow_d;
  logic [CNT_W-1:0]  edge_cnt_d;
  logic [GATE_W-1:0] first_edge_d;

  // Input synchronizers for every channel bit; selection happens downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], {sig_carrier, sig_1023k}};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Channel select as a one-hot mask; out-of-range channels read as constant 0.
  always_comb begin
    src_vec_c = src_q ? synced[IN_W-1:NUM_CH] : synced[NUM_CH-1:0];
    ch_mask_c = (32'(ch_q) < NUM_CH) ? (NUM_CH'(1) << ch_q) : '0;
    sel_c     = |(src_vec_c & ch_mask_c);
    rise_c    = sel_c & ~prev_q;
  end

  // Next-state, working counters and result capture.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    src_d        = src_q;
    len_d        = len_q;
    prev_d       = prev_q;
    gcnt_d       = gcnt_q;
    wcnt_d       = wcnt_q;
    wfirst_d     = wfirst_q;
    wseen_d      = wseen_q;
    wovf_d       = wovf_q;
    done_d       = 1'b0;
    edge_cnt_d   = edge_cnt;
    first_edge_d = first_edge;
    no_edge_d    = no_edge;
    overflow_d   = overflow;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d    = ch_sel;
          src_d   = src_sel;
          len_d   = gate_len;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        // Preload prev with the new channel so a channel switch is not an edge.
        prev_d   = sel_c;
        gcnt_d   = '0;
        wcnt_d   = '0;
        wfirst_d = '0;
        wseen_d  = 1'b0;
        wovf_d   = 1'b0;
        state_d  = (len_q == '0) ? S_DONE : S_GATE;
      end
      S_GATE: begin
        prev_d = sel_c;
        if (rise_c) begin
          if (!wseen_q) begin
            wfirst_d = gcnt_q;
            wseen_d  = 1'b1;
          end
          if (wcnt_q == {CNT_W{1'b1}}) wovf_d = 1'b1;
          else                         wcnt_d = wcnt_q + CNT_W'(1);
        end
        gcnt_d = gcnt_q + GATE_W'(1);
        if (gcnt_q == len_q - GATE_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results land in the output registers on entry to DONE.
    if (state_d == S_DONE) begin
      done_d       = 1'b1;
      edge_cnt_d   = wcnt_d;
      no_edge_d    = ~wseen_d;
      first_edge_d = wseen_d ? wfirst_d : {GATE_W{1'b1}};
      overflow_d   = wovf_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, configuration, working and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      src_q      <= 1'b0;
      len_q      <= '0;
      prev_q     <= 1'b0;
      gcnt_q     <= '0;
      wcnt_q     <= '0;
      wfirst_q   <= '0;
      wseen_q    <= 1'b0;
      wovf_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_cnt   <= '0;
      first_edge <= '0;
      no_edge    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      src_q      <= src_d;
      len_q      <= len_d;
      prev_q     <= prev_d;
      gcnt_q     <= gcnt_d;
      wcnt_q     <= wcnt_d;
      wfirst_q   <= wfirst_d;
      wseen_q    <= wseen_d;
      wovf_q     <= wovf_d;
      busy       <= busy_d;
      done       <= done_d;
      edge_cnt   <= edge_cnt_d;
      first_edge <= first_edge_d;
      no_edge    <= no_edge_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_nco_clk_meter.sv
// Bench for nco_clk_meter: two instances (full-width and 4-bit counter) share stimulus.
// A cycle-level model derives expected results from the recorded input history.
module tb_nco_clk_meter;

  localparam int NUM_CH = 8;
  localparam int GATE_W = 28;
  localparam int S      = 2;
  localparam int MAXC   = 8192;
  localparam int HUGE   = 1 << 30;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        ch_sel = '0;
  logic              src_sel = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;
  logic [NUM_CH-1:0] sig_1023k = '0;
  logic [NUM_CH-1:0] sig_carrier = '0;

  logic              busy_a, done_a, no_edge_a, ovf_a;
  logic [27:0]       cnt_a, first_a;
  logic              busy_b, done_b, no_edge_b, ovf_b;
  logic [3:0]        cnt_b;
  logic [27:0]       first_b;

  nco_clk_meter dut_a (
    .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .src_sel(src_sel),
    .gate_len(gate_len), .sig_1023k(sig_1023k), .sig_carrier(sig_carrier),
    .busy(busy_a), .done(done_a), .edge_cnt(cnt_a), .first_edge(first_a),
    .no_edge(no_edge_a), .overflow(ovf_a)
  );

  nco_clk_meter #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .src_sel(src_sel),
    .gate_len(gate_len), .sig_1023k(sig_1023k), .sig_carrier(sig_carrier),
    .busy(busy_b), .done(done_b), .edge_cnt(cnt_b), .first_edge(first_b),
    .no_edge(no_edge_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Input waveform generator: periodic square wave, or a single rise at a cycle.
  int per_code[NUM_CH] = '{10, 6, 4, 0, 8, 12, 14, 18};
  int per_carr[NUM_CH] = '{16, 22, 26, 30, 0, 34, 38, 42};
  int rise_code[NUM_CH] = '{HUGE, HUGE, HUGE, HUGE, HUGE, HUGE, HUGE, HUGE};
  int rise_carr[NUM_CH] = '{HUGE, HUGE, HUGE, HUGE, 0, HUGE, HUGE, HUGE};

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      sig_1023k[i]   = (per_code[i] != 0) ? ((cyc % per_code[i]) >= per_code[i] / 2)
                                          : (cyc >= rise_code[i]);
      sig_carrier[i] = (per_carr[i] != 0) ? ((cyc % per_carr[i]) >= per_carr[i] / 2)
                                          : (cyc >= rise_carr[i]);
    end
  end

  // Model: inputs seen during cycle c are counted if they rise between the ARM
  // sample and the end of the gate, shifted by the synchronizer latency.
  logic [2*NUM_CH-1:0] hist [0:MAXC-1];
  bit          m_busy = 1'b0;
  int          m_t, m_l, m_d, m_ch;
  bit          m_src;
  logic        e_busy = 1'b0, e_done = 1'b0, e_noedge = 1'b0, e_ovf_a = 1'b0, e_ovf_b = 1'b0;
  logic [27:0] e_cnt_a = '0, e_first = '0;
  logic [3:0]  e_cnt_b = '0;

  always @(posedge clk) begin : model
    int c, n, e, fk, b;
    c = cyc;
    if (c < MAXC) hist[c] = {sig_carrier, sig_1023k};
    if (rst) begin
      m_busy = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_noedge = 1'b0; e_ovf_a = 1'b0; e_ovf_b = 1'b0;
      e_cnt_a = '0; e_first = '0; e_cnt_b = '0;
    end else begin
      if (!m_busy && start === 1'b1) begin
        m_busy = 1'b1;
        m_t = c; m_l = int'(gate_len); m_ch = int'(ch_sel); m_src = src_sel;
        m_d = c + 2 + m_l;
      end else if (m_busy && c == m_d) begin
        m_busy = 1'b0;
      end
      n = c + 1;
      e_done = m_busy && (n == m_d);
      e_busy = m_busy && (n <= m_d);
      if (e_done) begin
        e = 0; fk = 0;
        b = m_src ? NUM_CH + m_ch : m_ch;
        for (int j = m_t + 2 - S; j <= m_t + 1 + m_l - S; j++) begin
          if (hist[j][b] && !hist[j-1][b]) begin
            if (e == 0) fk = j + S - m_t - 2;
            e++;
          end
        end
        e_cnt_a  = 28'(e);
        e_ovf_a  = 1'b0;
        e_cnt_b  = (e > 15) ? 4'hF : 4'(e);
        e_ovf_b  = (e > 15);
        e_noedge = (e == 0);
        e_first  = (e == 0) ? 28'hFFFFFFF : 28'(fk);
      end
    end
    cyc = c + 1;
    #1;
    chk("busy_a", 64'(busy_a), 64'(e_busy));
    chk("done_a", 64'(done_a), 64'(e_done));
    chk("edge_cnt_a", 64'(cnt_a), 64'(e_cnt_a));
    chk("first_edge_a", 64'(first_a), 64'(e_first));
    chk("no_edge_a", 64'(no_edge_a), 64'(e_noedge));
    chk("overflow_a", 64'(ovf_a), 64'(e_ovf_a));
    chk("busy_b", 64'(busy_b), 64'(e_busy));
    chk("done_b", 64'(done_b), 64'(e_done));
    chk("edge_cnt_b", 64'(cnt_b), 64'(e_cnt_b));
    chk("first_edge_b", 64'(first_b), 64'(e_first));
    chk("overflow_b", 64'(ovf_b), 64'(e_ovf_b));
  end

  // Issue a measurement; config inputs are scrambled right after start.
  task automatic run_meas(input int ch, input bit src, input int len, output int t);
    @(negedge clk);
    start = 1'b1; ch_sel = 3'(ch); src_sel = src; gate_len = GATE_W'(len);
    t = cyc;
    @(negedge clk);
    start = 1'b0; ch_sel = 3'(ch + 1); src_sel = ~src; gate_len = GATE_W'(5);
  endtask

  task automatic wait_done(input int t, input int len, input string name);
    bit got = 1'b0;
    for (int i = 0; i < len + 40; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no done seen, expected at cycle %0d", name, t + 2 + len);
    end else begin
      chk({name, "_latency"}, 64'(cyc - t), 64'(2 + len));
    end
  endtask

  initial begin : stim
    int t, ndone;
    logic [27:0] cap;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy_a), 64'(0));
    chk("reset_cnt", 64'(cnt_a), 64'(0));
    chk("reset_first", 64'(first_a), 64'(0));
    chk("reset_no_edge", 64'(no_edge_a), 64'(0));
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: ch0 code, rises every 10 clk, 1000-cycle gate
    run_meas(0, 1'b0, 1000, t);
    wait_done(t, 1000, "t1");
    chk("t1_cnt", 64'(cnt_a), 64'(100));
    chk("t1_no_edge", 64'(no_edge_a), 64'(0));
    chk("t1_overflow", 64'(ovf_a), 64'(0));
    repeat (3) @(negedge clk);

    // 2: zero-length gate
    run_meas(0, 1'b0, 0, t);
    wait_done(t, 0, "t2");
    chk("t2_cnt", 64'(cnt_a), 64'(0));
    chk("t2_no_edge", 64'(no_edge_a), 64'(1));
    chk("t2_first", 64'(first_a), 64'(28'hFFFFFFF));
    repeat (3) @(negedge clk);

    // 3: carrier ch4 held high throughout
    run_meas(4, 1'b1, 50, t);
    wait_done(t, 50, "t3");
    chk("t3_cnt", 64'(cnt_a), 64'(0));
    chk("t3_no_edge", 64'(no_edge_a), 64'(1));
    repeat (3) @(negedge clk);

    // 4: 20 edges saturate the 4-bit counter
    run_meas(2, 1'b0, 80, t);
    wait_done(t, 80, "t4");
    chk("t4_cnt_a", 64'(cnt_a), 64'(20));
    chk("t4_cnt_b", 64'(cnt_b), 64'(15));
    chk("t4_ovf_b", 64'(ovf_b), 64'(1));
    chk("t4_ovf_a", 64'(ovf_a), 64'(0));
    repeat (3) @(negedge clk);

    // 4b: single rise landing on gate cycle 37
    run_meas(3, 1'b0, 50, t);
    rise_code[3] = t + 37;
    wait_done(t, 50, "t4b");
    chk("t4b_first", 64'(first_a), 64'(37));
    chk("t4b_cnt", 64'(cnt_a), 64'(1));
    repeat (3) @(negedge clk);

    // 5: extra start while busy is ignored
    run_meas(0, 1'b0, 100, t);
    repeat (4) @(negedge clk);
    start = 1'b1; ch_sel = 3'd1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; cap = '0;
    for (int i = 0; i < 130; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin ndone++; cap = cnt_a; end
    end
    chk("t5_done_count", 64'(ndone), 64'(1));
    chk("t5_cnt", 64'(cap), 64'(10));
    repeat (3) @(negedge clk);

    // 6: reset during the gate aborts without a done
    run_meas(0, 1'b0, 200, t);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_busy", 64'(busy_a), 64'(0));
    chk("t6_rst_cnt", 64'(cnt_a), 64'(0));
    chk("t6_rst_done", 64'(done_a), 64'(0));
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) ndone++;
    end
    chk("t6_no_done", 64'(ndone), 64'(0));
    run_meas(0, 1'b0, 100, t);
    wait_done(t, 100, "t6b");
    chk("t6b_cnt", 64'(cnt_a), 64'(10));
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
